fwd_hazard_ctrl: RTL

//  Forwarding and load-use hazard controller for the 5-stage pipeline.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/fwd_sel_cmp.sv | 19 +
 rtl/fwd_hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline forwarding/hazard logic
package pipe_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_IMM   = 2'b11;
  typedef enum logic [0:0] {RUN = 1'b0, LU_STALL = 1'b1} lu_state_e;
endpackage

// File: rtl/fwd_sel_cmp.sv
// fwd_sel_cmp: picks the forwarding source for one operand, youngest writer first
module fwd_sel_cmp
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_vld,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_vld,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel
);
  always_comb
    sel = (!use_src || src == '0) ? FWD_RF :
          (ex_vld && ex_wr && ex_rd == src) ? FWD_EXMEM :
          (mem_vld && mem_wr && mem_rd == src) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: ID-stage tag pipeline, load-use stall FSM and registered EX mux selects
module fwd_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ex_flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
);
  lu_state_e state_q, state_d;
  logic ex_vld_q, ex_vld_d, ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
  logic mem_vld_q, mem_vld_d, mem_wr_q, mem_wr_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic ex_bubble_q, ex_bubble_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic lu, issue;
  fwd_sel_cmp u_cmp_a (
    .src(id_rs), .use_src(id_use_rs),
    .ex_vld(ex_vld_q), .ex_wr(ex_wr_q), .ex_rd(ex_rd_q),
    .mem_vld(mem_vld_q), .mem_wr(mem_wr_q), .mem_rd(mem_rd_q),
    .sel(sel_a)
  );
  fwd_sel_cmp u_cmp_b (
    .src(id_rt), .use_src(id_use_rt),
    .ex_vld(ex_vld_q), .ex_wr(ex_wr_q), .ex_rd(ex_rd_q),
    .mem_vld(mem_vld_q), .mem_wr(mem_wr_q), .mem_rd(mem_rd_q),
    .sel(sel_b)
  );
  // In LU_STALL, EX holds the bubble, so the re-presented instruction cannot re-trigger lu
  always_comb begin
    lu = id_valid && ex_vld_q && ex_ld_q && ex_wr_q && ex_rd_q != '0 &&
         ((id_use_rs && id_rs == ex_rd_q) || (id_use_rt && id_rt == ex_rd_q));
    stall = state_q == RUN && lu && !ex_flush && !hold;
    issue = id_valid && !ex_flush && !stall;
    state_d = stall ? LU_STALL : RUN;
    mem_vld_d = ex_vld_q;
    mem_wr_d = ex_wr_q;
    mem_rd_d = ex_rd_q;
    ex_vld_d = issue;
    ex_wr_d = issue && id_reg_write;
    ex_ld_d = issue && id_mem_read;
    ex_rd_d = id_rd;
    ex_bubble_d = !issue;
    fwd_a_d = issue ? sel_a : FWD_RF;
    fwd_b_d = !issue ? FWD_RF : id_use_imm ? FWD_IMM : sel_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_vld_q <= 1'b0;
      ex_wr_q <= 1'b0;
      ex_ld_q <= 1'b0;
      ex_rd_q <= '0;
      mem_vld_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= '0;
      ex_bubble_q <= 1'b1;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!hold) begin
      state_q <= state_d;
      ex_vld_q <= ex_vld_d;
      ex_wr_q <= ex_wr_d;
      ex_ld_q <= ex_ld_d;
      ex_rd_q <= ex_rd_d;
      mem_vld_q <= mem_vld_d;
      mem_wr_q <= mem_wr_d;
      mem_rd_q <= mem_rd_d;
      ex_bubble_q <= ex_bubble_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end
  assign ex_bubble = ex_bubble_q;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
endmodule
